// File: rtl/drive_cmd_pkg.sv
// Shared encodings for the framed drive command decoder.
// Constants only, no timing of its own.
// No flow control here; consumers handle their own handshakes.
package drive_cmd_pkg;

  // Opcode field CMD[7:6]
  localparam logic [1:0] OP_MOTOR = 2'b00;
  localparam logic [1:0] OP_REL   = 2'b01;
  localparam logic [1:0] OP_ABS   = 2'b10;
  localparam logic [1:0] OP_CTR   = 2'b11;

  // Motor direction encodings; 2'b10 is reserved and rejected
  localparam logic [1:0] DIR_FWD  = 2'b11;
  localparam logic [1:0] DIR_BWD  = 2'b00;
  localparam logic [1:0] DIR_HALT = 2'b01;
  localparam logic [1:0] DIR_RSVD = 2'b10;

  // Ack byte returned for any rejected frame
  localparam logic [7:0] ERR_ACK = 8'hEE;

  // Frame parser states
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_GOT_HDR = 3'd1,
    ST_GOT_CMD = 3'd2,
    ST_GOT_ARG = 3'd3,
    ST_EXEC    = 3'd4
  } state_e;

endpackage

// File: rtl/rx_strobe_sync.sv
// Synchronises the UART-domain completion level and emits a one-cycle strobe on its rising edge.
// Strobe is high in the third sys_clk cycle after the level rises (two sync flops plus edge detect).
// No backpressure: the strobe is a pulse and must be consumed in the cycle it is high.
module rx_strobe_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic level_i,
  output logic strobe_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchroniser plus a delayed copy used for rising-edge detection
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= level_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign strobe_o = sync_q & ~prev_q;

endmodule

// File: rtl/drive_cmd_decoder.sv
// Parses checksummed 4-byte frames from UART_RX and drives servo angles, motor direction and an ack byte.
// Outputs update at the end of the EXEC cycle, one cycle after the checksum byte is accepted.
// Ack register is one deep; a new ack overwrites an unaccepted one and the frame still executes.
module drive_cmd_decoder
  import drive_cmd_pkg::*;
#(
  parameter int unsigned NUM_SERVO     = 2,
  parameter int unsigned ANGLE_W       = 8,
  parameter int unsigned MIN_ANGLE     = 150,
  parameter int unsigned MAX_ANGLE     = 250,
  parameter int unsigned DEFAULT_ANGLE = 200,
  parameter int unsigned STEP          = 1,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT  = 100_000,
  parameter int unsigned WDOG_CYCLES   = 50_000_000
) (
  input  logic                           sys_clk,
  input  logic                           rst_n,
  input  logic                           rx_done,
  input  logic [7:0]                     rx_data,
  output logic [NUM_SERVO*ANGLE_W-1:0]   angle,
  output logic [1:0]                     direction,
  output logic                           ack_valid,
  input  logic                           ack_ready,
  output logic [7:0]                     ack_data,
  output logic                           frame_err,
  output logic                           timeout
);

  // Relative arithmetic is done wide and signed so add/subtract can never wrap
  localparam int XW = ANGLE_W + 8;
  localparam int TW = (BYTE_TIMEOUT < 2) ? 1 : $clog2(BYTE_TIMEOUT + 1);
  localparam logic signed [XW-1:0]  LO_X  = XW'(MIN_ANGLE);
  localparam logic signed [XW-1:0]  HI_X  = XW'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0]    DEF_A = ANGLE_W'(DEFAULT_ANGLE);

  logic                 byte_stb;
  state_e               state_q;
  logic [7:0]           cmd_q;
  logic [7:0]           arg_q;
  logic [7:0]           chk_q;
  logic [TW-1:0]        tmr_q;
  logic [31:0]          wdog_q;
  logic [ANGLE_W-1:0]   angle_q [NUM_SERVO];
  logic [1:0]           dir_q;
  logic                 ack_vld_q;
  logic [7:0]           ack_dat_q;
  logic                 ferr_q;
  logic                 tmo_q;

  logic [1:0]           op;
  logic [5:0]           ch;
  logic                 chan_ok;
  logic                 chk_ok;
  logic                 frame_ok;
  logic                 exec_ok;
  logic [ANGLE_W-1:0]   cur_angle;
  logic [ANGLE_W-1:0]   angle_d;
  logic signed [XW-1:0] cur_x;
  logic signed [XW-1:0] delta_x;
  logic signed [XW-1:0] tgt_x;

  rx_strobe_sync u_sync (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .level_i  (rx_done),
    .strobe_o (byte_stb)
  );

  // Decode the captured frame: validity checks and the clamped target angle for the addressed channel
  always_comb begin
    op        = cmd_q[7:6];
    ch        = cmd_q[5:0];
    cur_angle = '0;
    for (int k = 0; k < NUM_SERVO; k++) begin
      if (ch == 6'(k)) cur_angle = angle_q[k];
    end
    chan_ok = (32'(ch) < NUM_SERVO);
    chk_ok  = ((HEADER ^ cmd_q ^ arg_q) == chk_q);
    cur_x   = XW'(cur_angle);
    delta_x = XW'(arg_q[6:0]) * XW'(STEP);
    tgt_x   = arg_q[7] ? (cur_x + delta_x) : (cur_x - delta_x);
    if (op == OP_ABS) tgt_x = XW'(arg_q);
    if (tgt_x < LO_X)      angle_d = LO_X[ANGLE_W-1:0];
    else if (tgt_x > HI_X) angle_d = HI_X[ANGLE_W-1:0];
    else                   angle_d = tgt_x[ANGLE_W-1:0];
    frame_ok = chk_ok;
    case (op)
      OP_MOTOR:       if (arg_q[1:0] == DIR_RSVD) frame_ok = 1'b0;
      OP_REL, OP_ABS: if (!chan_ok) frame_ok = 1'b0;
      default:        ;
    endcase
    exec_ok = (state_q == ST_EXEC) && frame_ok;
  end

  // Frame FSM with inter-byte timer, watchdog and all registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      cmd_q     <= '0;
      arg_q     <= '0;
      chk_q     <= '0;
      tmr_q     <= '0;
      wdog_q    <= '0;
      for (int k = 0; k < NUM_SERVO; k++) angle_q[k] <= DEF_A;
      dir_q     <= DIR_HALT;
      ack_vld_q <= 1'b0;
      ack_dat_q <= 8'h00;
      ferr_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (ack_vld_q && ack_ready) ack_vld_q <= 1'b0;

      // A successful EXEC in the same cycle takes priority over a watchdog trip
      if ((WDOG_CYCLES != 0) && !tmo_q && !exec_ok) begin
        if (wdog_q >= 32'(WDOG_CYCLES - 1)) begin
          tmo_q <= 1'b1;
          dir_q <= DIR_HALT;
        end else begin
          wdog_q <= wdog_q + 32'd1;
        end
      end

      case (state_q)
        ST_HUNT: begin
          tmr_q <= '0;
          if (byte_stb && (rx_data == HEADER)) state_q <= ST_GOT_HDR;
        end
        ST_GOT_HDR, ST_GOT_CMD, ST_GOT_ARG: begin
          if (byte_stb) begin
            tmr_q <= '0;
            if (state_q == ST_GOT_HDR) begin
              cmd_q   <= rx_data;
              state_q <= ST_GOT_CMD;
            end else if (state_q == ST_GOT_CMD) begin
              arg_q   <= rx_data;
              state_q <= ST_GOT_ARG;
            end else begin
              chk_q   <= rx_data;
              state_q <= ST_EXEC;
            end
          end else if (tmr_q >= TW'(BYTE_TIMEOUT)) begin
            tmr_q   <= '0;
            ferr_q  <= 1'b1;
            state_q <= ST_HUNT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_EXEC: begin
          state_q   <= ST_HUNT;
          tmr_q     <= '0;
          ack_vld_q <= 1'b1;
          if (frame_ok) begin
            ack_dat_q <= cmd_q;
            wdog_q    <= '0;
            tmo_q     <= 1'b0;
            case (op)
              OP_MOTOR: dir_q <= arg_q[1:0];
              OP_REL, OP_ABS: begin
                for (int k = 0; k < NUM_SERVO; k++) begin
                  if (ch == 6'(k)) angle_q[k] <= angle_d;
                end
              end
              default: begin
                for (int k = 0; k < NUM_SERVO; k++) angle_q[k] <= DEF_A;
                dir_q <= DIR_HALT;
              end
            endcase
          end else begin
            ack_dat_q <= ERR_ACK;
            ferr_q    <= 1'b1;
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SERVO; k++) begin : g_angle
    assign angle[k*ANGLE_W +: ANGLE_W] = angle_q[k];
  end

  assign direction = dir_q;
  assign ack_valid = ack_vld_q;
  assign ack_data  = ack_dat_q;
  assign frame_err = ferr_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_drive_cmd_decoder.sv
`timescale 1ns/1ps
module tb_drive_cmd_decoder;

  localparam int NS   = 2;
  localparam int AW   = 8;
  localparam int MINA = 150;
  localparam int MAXA = 250;
  localparam int DEFA = 200;
  localparam int STP  = 1;
  localparam int BTO  = 40;
  localparam int WDOG = 3000;

  logic             sys_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_done = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic [NS*AW-1:0] angle;
  logic [1:0]       direction;
  logic             ack_valid;
  logic             ack_ready = 1'b0;
  logic [7:0]       ack_data;
  logic             frame_err;
  logic             timeout;

  always #5 sys_clk = ~sys_clk;

  drive_cmd_decoder #(
    .NUM_SERVO(NS), .ANGLE_W(AW), .MIN_ANGLE(MINA), .MAX_ANGLE(MAXA),
    .DEFAULT_ANGLE(DEFA), .STEP(STP), .HEADER(8'hA5),
    .BYTE_TIMEOUT(BTO), .WDOG_CYCLES(WDOG)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .angle(angle), .direction(direction), .ack_valid(ack_valid),
    .ack_ready(ack_ready), .ack_data(ack_data), .frame_err(frame_err),
    .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_ang [NS];
  int m_dir;
  int m_tmo;
  int m_ackv;
  int m_ackd;
  int m_err = 0;
  int seen_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < MINA) return MINA;
    if (v > MAXA) return MAXA;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) m_ang[k] = DEFA;
    m_dir  = 1;
    m_tmo  = 0;
    m_ackv = 0;
    m_ackd = 0;
  endtask

  // Apply one complete frame (header already A5) to the model
  task automatic model_frame(input int c, input int a, input int k);
    int op, ch, v;
    bit ok;
    op = c / 64;
    ch = c % 64;
    ok = (k == (8'hA5 ^ c ^ a));
    if (op == 0 && (a % 4) == 2) ok = 0;
    if ((op == 1 || op == 2) && ch >= NS) ok = 0;
    m_ackv = 1;
    if (!ok) begin
      m_ackd = 8'hEE;
      m_err++;
    end else begin
      m_ackd = c;
      m_tmo  = 0;
      case (op)
        0: m_dir = a % 4;
        1: begin
          v = (a >= 128) ? m_ang[ch] + (a % 128) * STP : m_ang[ch] - (a % 128) * STP;
          m_ang[ch] = clampi(v);
        end
        2: m_ang[ch] = clampi(a);
        default: begin
          for (int i = 0; i < NS; i++) m_ang[i] = DEFA;
          m_dir = 1;
        end
      endcase
    end
  endtask

  // frame_err sampled just before each edge so each high cycle counts once
  always @(posedge sys_clk) if (frame_err) seen_err++;

  // Continuous comparison against the model while outputs are settled
  always @(negedge sys_clk) begin
    if (chk_en) begin
      for (int k = 0; k < NS; k++)
        check($sformatf("angle%0d", k), int'(angle[k*AW +: AW]), m_ang[k]);
      check("direction", int'(direction), m_dir);
      check("timeout", int'(timeout), m_tmo);
      check("ack_valid", int'(ack_valid), m_ackv);
      check("ack_data", int'(ack_data), m_ackd);
      check("frame_err_count", seen_err, m_err);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (4) @(negedge sys_clk);
    rx_done = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic send_frame(input int c, input int a, input int k);
    chk_en = 1'b0;
    send_byte(8'hA5);
    send_byte(8'(c));
    send_byte(8'(a));
    send_byte(8'(k));
    repeat (2) @(negedge sys_clk);
    model_frame(c, a, k);
    chk_en = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge sys_clk);
    check("rst_angle0", int'(angle[7:0]), 200);
    check("rst_angle1", int'(angle[15:8]), 200);
    check("rst_dir", int'(direction), 1);
    check("rst_ack_valid", int'(ack_valid), 0);
    check("rst_ack_data", int'(ack_data), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Motor forward
    send_frame(8'h00, 8'h03, 8'hA6);
    check("f1_dir", int'(direction), 3);
    check("f1_ack", int'(ack_data), 8'h00);
    check("f1_ackv", int'(ack_valid), 1);

    // Stray non-header byte in HUNT is ignored
    send_byte(8'h3C);

    // Relative +5 on channel 1, then -127 on channel 0 saturates low
    send_frame(8'h41, 8'h85, 8'h61);
    check("rel_up_ch1", int'(angle[15:8]), 205);
    check("rel_up_ack", int'(ack_data), 8'h41);
    send_frame(8'h40, 8'h7F, 8'h9A);
    check("rel_sat_lo_ch0", int'(angle[7:0]), 150);

    // Absolute 255 clamps high; relative +127 on channel 1 saturates high
    send_frame(8'h80, 8'hFF, 8'hDA);
    check("abs_clamp_ch0", int'(angle[7:0]), 250);
    send_frame(8'h41, 8'hFF, 8'h1B);
    check("rel_sat_hi_ch1", int'(angle[15:8]), 250);

    // Channel out of range
    send_frame(8'h42, 8'h05, 8'hE2);
    check("badch_ack", int'(ack_data), 8'hEE);
    check("badch_errs", seen_err, 1);
    check("badch_ch0", int'(angle[7:0]), 250);

    // Bad checksum, then a valid backward command
    send_frame(8'h00, 8'h03, 8'h00);
    check("badchk_ack", int'(ack_data), 8'hEE);
    check("badchk_dir", int'(direction), 3);
    send_frame(8'h00, 8'h00, 8'hA5);
    check("bwd_dir", int'(direction), 0);
    check("bwd_ack", int'(ack_data), 8'h00);

    // Reserved motor code
    send_frame(8'h00, 8'h02, 8'hA7);
    check("rsvd_errs", seen_err, 3);
    check("rsvd_dir", int'(direction), 0);

    // Ack handshake
    chk_en = 1'b0;
    ack_ready = 1'b1;
    @(negedge sys_clk);
    ack_ready = 1'b0;
    m_ackv = 0;
    chk_en = 1'b1;
    @(negedge sys_clk);
    check("ack_accepted", int'(ack_valid), 0);

    // Inter-byte timeout: no ack, one frame_err
    chk_en = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (BTO + 10) @(negedge sys_clk);
    m_err++;
    chk_en = 1'b1;
    @(negedge sys_clk);
    check("tmo_errs", seen_err, 4);
    check("tmo_no_ack", int'(ack_valid), 0);
    send_frame(8'h00, 8'h03, 8'hA6);
    check("after_tmo_dir", int'(direction), 3);

    // Watchdog: stays clear until near expiry, then halts
    repeat (WDOG - 50) @(negedge sys_clk);
    check("wdog_pre_tmo", int'(timeout), 0);
    chk_en = 1'b0;
    repeat (100) @(negedge sys_clk);
    m_tmo = 1;
    m_dir = 1;
    chk_en = 1'b1;
    @(negedge sys_clk);
    check("wdog_tmo", int'(timeout), 1);
    check("wdog_dir", int'(direction), 1);
    check("wdog_ch1_kept", int'(angle[15:8]), 250);
    send_frame(8'hC0, 8'h00, 8'h65);
    check("ctr_tmo", int'(timeout), 0);
    check("ctr_ch0", int'(angle[7:0]), 200);
    check("ctr_ch1", int'(angle[15:8]), 200);
    check("ctr_ack", int'(ack_data), 8'hC0);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h81, 8'hAA, 8'h8E);
    check("abs_ch1", int'(angle[15:8]), 170);
    chk_en = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h80);
    rst_n = 1'b0;
    #1;
    check("arst_ch1", int'(angle[15:8]), 200);
    check("arst_ackv", int'(ack_valid), 0);
    check("arst_dir", int'(direction), 1);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    send_frame(8'h80, 8'hA0, 8'h85);
    check("post_rst_ch0", int'(angle[7:0]), 160);
    repeat (5) @(negedge sys_clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_cmd_decoder.md
# drive_cmd_decoder

Framed command decoder between `UART_RX` and the vehicle actuators. It replaces the single-byte motor/servo decode in the top level with a checksummed 4-byte protocol. The protocol addresses `NUM_SERVO` channels, supports absolute and relative angle commands, and enforces an inter-byte timeout and a link-loss watchdog that halts the motor. It runs on `sys_clk`, synchronises the UART completion strobe itself, and returns an acknowledge byte toward `UART_TX`.

## Interface
- `NUM_SERVO`, 2: number of servo channels, 1..64.
- `ANGLE_W`, 8: angle width, 8..16.
- `MIN_ANGLE` / `MAX_ANGLE` / `DEFAULT_ANGLE`, 150 / 250 / 200: clamp limits and reset/centre value.
- `STEP`, 1: angle units per relative step count.
- `HEADER`, 8'hA5: frame start byte.
- `BYTE_TIMEOUT`, 100_000: maximum `sys_clk` cycles between bytes inside a frame.
- `WDOG_CYCLES`, 50_000_000: cycles without a valid frame before halt. 0 disables the watchdog.

Ports:
- `sys_clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_done`  in  1  `UART_RX` finish level from the `clk_uart` domain; asynchronous to `sys_clk`.
- `rx_data`  in  8  received byte; stable while `rx_done` is high.
- `angle`  out  `NUM_SERVO*ANGLE_W`  servo targets; channel k occupies bits [k*ANGLE_W +: ANGLE_W].
- `direction`  out  2  motor: 2'b11 forward, 2'b00 backward, 2'b01 halt.
- `ack_valid`  out  1  acknowledge byte pending.
- `ack_ready`  in  1  consumer accepts the ack when it is high together with `ack_valid`.
- `ack_data`  out  8  acknowledge byte.
- `frame_err`  out  1  one-cycle pulse per rejected frame.
- `timeout`  out  1  level; high while the watchdog has tripped.

## Operation
- Frame format: HEADER, CMD, ARG, CHK, with CHK = HEADER ^ CMD ^ ARG.
- Opcodes, selected by CMD[7:6]:
  - 00 motor: ARG[1:0] is loaded into `direction`. ARG[1:0]=2'b10 is an error.
  - 01 relative servo on channel CMD[5:0]: ARG[7]=1 increases the angle, ARG[7]=0 decreases it. Delta = ARG[6:0]*STEP. The result saturates to [MIN_ANGLE, MAX_ANGLE].
  - 10 absolute servo on channel CMD[5:0]: ARG is zero-extended to ANGLE_W, then clamped.
  - 11 centre: every channel is set to DEFAULT_ANGLE and `direction` to halt.
- Relative arithmetic is computed at ANGLE_W+8 bits and signed before clamping, so no wrap-around can occur.
- Errors: checksum mismatch, channel >= NUM_SERVO, reserved motor code, or inter-byte timeout. On any error no output changes, `frame_err` pulses, `ack_data`=8'hEE, and the FSM returns to HUNT. An inter-byte timeout raises no ack.
- Successful frame: `ack_data`=CMD. The watchdog counter restarts and `timeout` clears.
- FSM states: HUNT → (byte==HEADER) GOT_HDR → GOT_CMD → GOT_ARG → EXEC → HUNT.
  - In HUNT, non-header bytes are discarded silently.
  - A HEADER value appearing mid-frame is treated as data; there is no resync.
- Watchdog: when WDOG_CYCLES elapse with no successful frame, `direction` is forced to halt and `timeout` goes to 1. Angles are untouched. The condition clears on the next successful frame.
- Ack register is one deep. A new ack replaces a pending unaccepted ack; the frame still executes.

## Timing
- Reset values: `angle` = DEFAULT_ANGLE on every channel, `direction` = 2'b01, `ack_valid` = 0, `ack_data` = 8'h00, `frame_err` = 0, `timeout` = 0, FSM = HUNT, all counters = 0.
- `rx_done` passes through a 2-flop synchroniser plus a rising-edge detect. A byte is accepted 3 `sys_clk` cycles after `rx_done` rises; `rx_data` is sampled in that same cycle.
- Output latency: CHK accepted in cycle N → EXEC in cycle N+1. `angle`/`direction`/`ack_valid`/`ack_data`/`frame_err` update at the end of cycle N+1, so they are visible from N+2.
- `ack_valid` stays high until a cycle with `ack_ready` high; it deasserts on the following edge.
- Inter-byte timer: resets on each accepted byte; counts only outside HUNT. It expires at BYTE_TIMEOUT and returns the FSM to HUNT in the next cycle.
- Watchdog expiry coinciding with a successful EXEC: EXEC wins; `timeout` stays 0 and `direction` takes the commanded value.
- Asserting reset mid-frame discards the partial frame; all outputs return to their reset values immediately, asynchronously.

## Structure
- Package `drive_cmd_pkg`: opcode constants, direction encodings (FWD/BWD/HALT), ERR_ACK = 8'hEE, FSM state enum.
- Sub-module `rx_strobe_sync`: 2-flop synchroniser plus rising-edge detector, producing a one-cycle `byte_strobe`.

## Test plan
- Reset → all angles 200, `direction`=01; send A5 00 03 A6 → `direction`=11, `ack_data`=00.
- Send A5 41 85 61 → channel 1 angle 200→205, ack 41; then A5 40 7F 9A → channel 0 saturates at 150.
- Send A5 80 FF DA → channel 0 clamps at 250; then A5 42 05 E2 (channel 2, NUM_SERVO=2) → `frame_err` pulse, ack EE, angles unchanged.
- Send a bad checksum A5 00 03 00 → error ack EE, `direction` unchanged; the next valid frame is decoded normally.
- Send A5 00, then wait BYTE_TIMEOUT+1 cycles → `frame_err` pulse, no ack; a following full frame is accepted.
- With `direction`=11, idle for WDOG_CYCLES → `direction`=01 and `timeout`=1; send A5 C0 00 65 → `timeout`=0, all angles 200.
